// File: rtl/udp_instr_pkg.sv
// Shared constants, FSM encoding and frame byte builder for the instruction frame generator.
// Latency: none (package only).
// Backpressure: n/a.
package udp_instr_pkg;

   localparam logic [7:0] HDR0    = 8'hA5;
   localparam logic [7:0] HDR1    = 8'h5A;
   localparam logic [7:0] TRAILER = 8'h0D;

   localparam int FRAME_LEN = 8;

   localparam logic [7:0] OP_KEY2 = 8'h01;
   localparam logic [7:0] OP_KEY3 = 8'h02;
   localparam logic [7:0] OP_KEY4 = 8'h03;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   // Everything about a frame that is frozen when it is scheduled.
   typedef struct packed {
      logic [7:0]  opcode;
      logic [7:0]  seq;
      logic [15:0] arg;
   } frame_ctx_t;

   // Byte idx of a frame; the checksum folds opcode, seq and both argument bytes.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input frame_ctx_t ctx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = HDR0;
         3'd1:    b = HDR1;
         3'd2:    b = ctx.opcode;
         3'd3:    b = ctx.seq;
         3'd4:    b = ctx.arg[15:8];
         3'd5:    b = ctx.arg[7:0];
         3'd6:    b = ctx.opcode ^ ctx.seq ^ ctx.arg[15:8] ^ ctx.arg[7:0];
         default: b = TRAILER;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low button and flags the accepted press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; press is combinational on the edge the level falls.
// Backpressure: none; press is a single-cycle pulse that the consumer must latch.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_50,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;
   logic          flip;

   // The synced level has disagreed with the accepted level for the full window this cycle.
   assign flip  = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign press = flip & level;

   // Two-flop synchroniser (idles released) plus a run-length counter that any bounce restarts.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], key_n};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (flip) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/udp_instr_frame_gen.sv
// Turns debounced key presses into 8-byte instruction frames for the UDP stack's app TX port.
// Latency: tx_req 2 cycles after a pending flag sets in IDLE; first byte valid the cycle after tx_ack.
// Backpressure: bytes hold on tx_valid & !tx_ready; presses queue in per-key pending flags.
module udp_instr_frame_gen
   import udp_instr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ACK_TIMEOUT     = 65535,
   parameter int IFG_CYCLES      = 32
) (
   input  logic        clk_50,
   input  logic        rst,
   input  logic [2:0]  key_n,
   input  logic [15:0] cmd_arg,
   output logic        tx_req,
   output logic [15:0] tx_len,
   input  logic        tx_ack,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic [7:0]  last_opcode,
   output logic [15:0] frame_cnt,
   output logic        err_drop,
   output logic        err_timeout
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int GW = $clog2(IFG_CYCLES + 1);

   logic [2:0]    press;
   logic [2:0]    pending;
   logic [2:0]    grant;
   logic [2:0]    cur_key;
   logic [2:0]    pend_clr;
   logic [7:0]    grant_op;
   logic [1:0]    state;
   logic [2:0]    idx;
   logic [7:0]    seq;
   logic [TW-1:0] timer;
   logic [GW-1:0] gap_cnt;
   frame_ctx_t    ctx;
   logic          frame_done;
   logic          ack_tmo;

   for (genvar k = 0; k < 3; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk_50 (clk_50),
         .rst    (rst),
         .key_n  (key_n[k]),
         .press  (press[k])
      );
   end

   assign tx_len = tx_req ? 16'(FRAME_LEN) : 16'd0;

   // Fixed priority key2 > key3 > key4 among pending presses.
   always_comb begin
      grant    = 3'b000;
      grant_op = OP_KEY4;
      if (pending[0]) begin
         grant    = 3'b001;
         grant_op = OP_KEY2;
      end else if (pending[1]) begin
         grant    = 3'b010;
         grant_op = OP_KEY3;
      end else if (pending[2]) begin
         grant    = 3'b100;
         grant_op = OP_KEY4;
      end
   end

   // A frame retires its key either by completing or by giving up on the ack.
   always_comb begin
      frame_done = (state == ST_SEND) && tx_valid && tx_ready && (idx == 3'd7);
      ack_tmo    = (state == ST_REQ) && tx_req && !tx_ack && (timer == TW'(ACK_TIMEOUT - 1));
      pend_clr   = (frame_done || ack_tmo) ? cur_key : 3'b000;
   end

   // Pending flags: a retiring key may be re-armed on the same edge; a press on a live flag is lost.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         pending  <= 3'b000;
         err_drop <= 1'b0;
      end else begin
         pending <= (pending & ~pend_clr) | press;
         if (|(press & pending & ~pend_clr)) begin
            err_drop <= 1'b1;
         end
      end
   end

   // Frame FSM: schedule, request, stream eight bytes, then enforce the inter-frame gap.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state       <= ST_IDLE;
         tx_req      <= 1'b0;
         tx_valid    <= 1'b0;
         tx_last     <= 1'b0;
         tx_data     <= 8'd0;
         idx         <= 3'd0;
         seq         <= 8'd0;
         frame_cnt   <= 16'd0;
         last_opcode <= 8'd0;
         err_timeout <= 1'b0;
         timer       <= '0;
         gap_cnt     <= '0;
         cur_key     <= 3'b000;
         ctx         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|pending) begin
                  ctx.opcode <= grant_op;
                  ctx.seq    <= seq;
                  ctx.arg    <= cmd_arg;
                  cur_key    <= grant;
                  timer      <= '0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!tx_req) begin
                  tx_req <= 1'b1;
               end else if (tx_ack) begin
                  tx_req   <= 1'b0;
                  tx_valid <= 1'b1;
                  tx_data  <= frame_byte(3'd0, ctx);
                  tx_last  <= 1'b0;
                  idx      <= 3'd0;
                  state    <= ST_SEND;
               end else if (ack_tmo) begin
                  tx_req      <= 1'b0;
                  err_timeout <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= ST_GAP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_SEND: begin
               if (tx_ready) begin
                  if (idx == 3'd7) begin
                     tx_valid    <= 1'b0;
                     tx_last     <= 1'b0;
                     tx_data     <= 8'd0;
                     seq         <= seq + 8'd1;
                     frame_cnt   <= frame_cnt + 16'd1;
                     last_opcode <= ctx.opcode;
                     gap_cnt     <= '0;
                     state       <= ST_GAP;
                  end else begin
                     idx     <= idx + 3'd1;
                     tx_data <= frame_byte(idx + 3'd1, ctx);
                     tx_last <= (idx == 3'd6);
                  end
               end
            end
            default: begin
               if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_instr_frame_gen.sv
// Directed and randomised bench for the instruction frame generator.
// Latency: n/a.
// Backpressure: bench drives tx_ready patterns and tx_ack delays.
module tb_udp_instr_frame_gen;
   import udp_instr_pkg::*;

   localparam int DEB = 16;
   localparam int ATO = 50;
   localparam int IFG = 32;

   logic        clk_50 = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  key_n = 3'b111;
   logic [15:0] cmd_arg = 16'd0;
   logic        tx_ack = 1'b0;
   logic        tx_ready = 1'b1;
   logic        tx_req;
   logic [15:0] tx_len;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_last;
   logic [7:0]  last_opcode;
   logic [15:0] frame_cnt;
   logic        err_drop;
   logic        err_timeout;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  model_seq = 8'd0;
   logic [15:0] model_cnt = 16'd0;
   logic [15:0] cur_arg = 16'd0;
   logic [7:0]  got[$];
   longint      last_end_t = 0;

   udp_instr_frame_gen #(
      .DEBOUNCE_CYCLES (DEB),
      .ACK_TIMEOUT     (ATO),
      .IFG_CYCLES      (IFG)
   ) dut (
      .clk_50      (clk_50),
      .rst         (rst),
      .key_n       (key_n),
      .cmd_arg     (cmd_arg),
      .tx_req      (tx_req),
      .tx_len      (tx_len),
      .tx_ack      (tx_ack),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_last     (tx_last),
      .tx_ready    (tx_ready),
      .last_opcode (last_opcode),
      .frame_cnt   (frame_cnt),
      .err_drop    (err_drop),
      .err_timeout (err_timeout)
   );

   always #5 clk_50 = ~clk_50;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame straight from the byte layout: header, opcode, seq, arg, xor checksum, trailer.
   function automatic logic [63:0] exp_frame(input logic [7:0] op, input logic [7:0] s, input logic [15:0] a);
      logic [7:0] c;
      c = op ^ s ^ a[15:8] ^ a[7:0];
      return {8'hA5, 8'h5A, op, s, a[15:8], a[7:0], c, 8'h0D};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      key_n = 3'b111;
      tx_ack = 1'b0;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk_50);
      rst = 1'b0;
      model_seq = 8'd0;
      model_cnt = 16'd0;
   endtask

   task automatic press(input logic [2:0] mask, input int hold);
      key_n = key_n & ~mask;
      repeat (hold) @(negedge clk_50);
      key_n = key_n | mask;
   endtask

   task automatic new_arg();
      cur_arg = 16'($urandom);
      cmd_arg = cur_arg;
   endtask

   task automatic wait_req(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (tx_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk_50);
      end
   endtask

   // Handles one frame end to end; abort_at >= 0 stops with that many bytes delivered.
   task automatic recv_frame(input logic [7:0] op, input int ack_dly, input bit bp,
                             input bit gap_chk, input int abort_at);
      bit          seen;
      bit          stalled;
      logic [7:0]  held;
      logic [63:0] packed_got;
      int          cyc;
      got.delete();
      wait_req(3000, seen);
      chk("req_seen", 64'(seen), 64'd1);
      if (!seen) return;
      if (gap_chk) chk("ifg_idle", 64'((($time - last_end_t) / 10 - 1) >= IFG), 64'd1);
      chk("tx_len", 64'(tx_len), 64'd8);
      cmd_arg = 16'($urandom);
      repeat (ack_dly) @(negedge clk_50);
      tx_ack = 1'b1;
      @(negedge clk_50);
      tx_ack = 1'b0;
      chk("first_valid", 64'(tx_valid), 64'd1);
      stalled = 1'b0;
      held = 8'd0;
      cyc = 0;
      while (got.size() < 8 && cyc < 200) begin
         if (abort_at >= 0 && got.size() == abort_at) return;
         if (stalled) begin
            chk("stall_hold", 64'({tx_valid, tx_data}), 64'({1'b1, held}));
            stalled = 1'b0;
         end
         tx_ready = bp ? cyc[0] : 1'b1;
         if (tx_valid === 1'b1) begin
            if (tx_ready) begin
               got.push_back(tx_data);
               chk("tx_last", 64'(tx_last), 64'(got.size() == 8));
            end else begin
               held = tx_data;
               stalled = 1'b1;
            end
         end
         @(negedge clk_50);
         cyc++;
      end
      tx_ready = 1'b1;
      last_end_t = longint'($time) - 10;
      packed_got = '0;
      for (int i = 0; i < 8; i++) begin
         packed_got = {packed_got[55:0], (i < got.size()) ? got[i] : 8'hxx};
      end
      chk("frame_bytes", packed_got, exp_frame(op, model_seq, cur_arg));
      chk("valid_drop", 64'(tx_valid), 64'd0);
      model_seq = model_seq + 8'd1;
      model_cnt = model_cnt + 16'd1;
      chk("frame_cnt", 64'(frame_cnt), 64'(model_cnt));
      chk("last_opcode", 64'(last_opcode), 64'(op));
      new_arg();
   endtask

   initial begin
      bit seen;
      bit saw;
      int n;
      logic [2:0] pend_seen;

      // Reset state
      do_reset();
      chk("rst_tx_req", 64'(tx_req), 64'd0);
      chk("rst_tx_len", 64'(tx_len), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_tx_last", 64'(tx_last), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_last_op", 64'(last_opcode), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_err_drop", 64'(err_drop), 64'd0);
      chk("rst_err_tmo", 64'(err_timeout), 64'd0);

      // Single key3 press, arg 0x1234, ack 3 cycles after tx_req, latency from pending to tx_req
      cur_arg = 16'h1234;
      cmd_arg = cur_arg;
      key_n[1] = 1'b0;
      n = 0;
      while (dut.pending === 3'b000 && n < 200) begin
         @(negedge clk_50);
         n++;
      end
      chk("pend_set", 64'(dut.pending), 64'b010);
      n = 0;
      while (tx_req !== 1'b1 && n < 10) begin
         @(negedge clk_50);
         n++;
      end
      chk("req_latency", 64'(n), 64'd2);
      recv_frame(OP_KEY3, 3, 1'b0, 1'b0, -1);
      key_n = 3'b111;
      chk("single_literal", exp_frame(OP_KEY3, 8'h00, 16'h1234), 64'hA55A02001234240D);
      chk("single_cnt", 64'(frame_cnt), 64'd1);

      // Bounce on key2 never reaches the debounce window
      repeat (40) @(negedge clk_50);
      saw = 1'b0;
      pend_seen = 3'b000;
      for (int i = 0; i < 20; i++) begin
         key_n[0] = ~key_n[0];
         repeat (5) begin
            @(negedge clk_50);
            saw = saw | tx_req;
            pend_seen = pend_seen | dut.pending;
         end
      end
      key_n[0] = 1'b1;
      repeat (60) begin
         @(negedge clk_50);
         saw = saw | tx_req;
         pend_seen = pend_seen | dut.pending;
      end
      chk("bounce_req", 64'(saw), 64'd0);
      chk("bounce_pend", 64'(pend_seen), 64'd0);
      chk("bounce_drop", 64'(err_drop), 64'd0);

      // Backpressure: tx_ready low every other cycle
      new_arg();
      press(3'b001, 40);
      recv_frame(OP_KEY2, 2, 1'b1, 1'b1, -1);

      // Random single-key frames with random ack delay and backpressure
      for (int r = 0; r < 4; r++) begin
         int k;
         k = $urandom_range(0, 2);
         new_arg();
         press(3'(1 << k), 40);
         recv_frame(8'(k + 1), $urandom_range(1, 10), 1'($urandom_range(0, 1)), 1'b1, -1);
      end

      // Simultaneous presses: priority order and seq increments, with gap enforced
      do_reset();
      new_arg();
      press(3'b111, 40);
      recv_frame(OP_KEY2, 3, 1'b0, 1'b0, -1);
      recv_frame(OP_KEY3, 1, 1'b0, 1'b1, -1);
      recv_frame(OP_KEY4, 5, 1'b1, 1'b1, -1);
      chk("simul_seq_model", 64'(model_seq), 64'd3);

      // Ack timeout with a second key4 press landing while the first is still pending
      do_reset();
      new_arg();
      press(3'b100, 20);
      repeat (25) @(negedge clk_50);
      press(3'b100, 20);
      n = 0;
      wait_req(100, seen);
      while (tx_req === 1'b1 && n < 200) begin
         @(negedge clk_50);
         n++;
      end
      chk("tmo_req_drop", 64'(tx_req), 64'd0);
      chk("tmo_err", 64'(err_timeout), 64'd1);
      chk("tmo_drop", 64'(err_drop), 64'd1);
      chk("tmo_frame_cnt", 64'(frame_cnt), 64'd0);
      saw = 1'b0;
      repeat (60) begin
         @(negedge clk_50);
         saw = saw | tx_req;
      end
      chk("tmo_no_retry", 64'(saw), 64'd0);
      new_arg();
      press(3'b100, 40);
      recv_frame(OP_KEY4, 2, 1'b0, 1'b0, -1);

      // Reset while byte 3 is on the bus
      new_arg();
      press(3'b001, 40);
      recv_frame(OP_KEY2, 2, 1'b0, 1'b0, 3);
      chk("pre_rst_valid", 64'(tx_valid), 64'd1);
      chk("pre_rst_data", 64'(tx_data), 64'(model_seq));
      rst = 1'b1;
      @(negedge clk_50);
      chk("mid_rst_valid", 64'(tx_valid), 64'd0);
      chk("mid_rst_req", 64'(tx_req), 64'd0);
      chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
      chk("mid_rst_seq", 64'(dut.seq), 64'd0);
      rst = 1'b0;
      model_seq = 8'd0;
      model_cnt = 16'd0;
      new_arg();
      press(3'b001, 40);
      recv_frame(OP_KEY2, 3, 1'b0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
